// File: rtl/freq_meter_pkg.sv
// Shared types and constant helpers for the auto-ranging frequency meter.
package freq_meter_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_PERIOD,
        S_GATE,
        S_SCALE,
        S_RECIP,
        S_NORM,
        S_BCD,
        S_DONE
    } t_state;

    typedef enum logic [1:0] {
        e_mode_period = 2'd0,
        e_mode_gate   = 2'd1,
        e_mode_auto   = 2'd2
    } t_mode;

    // Encoding 3 is folded onto auto.
    function automatic t_mode decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return e_mode_period;
            2'd1:    return e_mode_gate;
            default: return e_mode_auto;
        endcase
    endfunction

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_meter_autorange_div.sv
// Restoring divider, one quotient bit per cycle; o_done pulses with the quotient valid.
module div_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, dvs_q});
        rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (i_start) begin
            rem_q  <= '0;
            quo_q  <= i_dividend;
            dvs_q  <= i_divisor;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= fits ? rem_sub : rem_sh[WIDTH-1:0];
            quo_q  <= {quo_q[WIDTH-2:0], fits};
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= (cnt_q != CW'(1));
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign o_done     = done_q;
    assign o_quotient = quo_q;

endmodule

// File: rtl/freq_meter_autorange.sv
// Auto-ranging frequency meter: reciprocal or gated measurement, normalised to DIGITS BCD digits.
module freq_meter_autorange
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned AUTO_THRESH = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic                  i_continuous,
    input  logic                  i_signal,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_dp,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic                  o_ready,
    output logic                  o_done
);

    localparam int unsigned      DIV_W     = $clog2(64'(CLK_FREQ) * 64'd1000) + 1;
    localparam logic [63:0]      LIMIT     = pow10(DIGITS);
    localparam int unsigned      BIN_W     = $clog2(LIMIT);
    localparam int unsigned      CNT_W     = $clog2(BIN_W) + 1;
    localparam logic [DIV_W-1:0] RECIP_NUM = DIV_W'(64'(CLK_FREQ) * 64'd1000);

    logic [2:0] sync_q;
    logic       edge_q;

    t_state state_q, state_d;
    t_mode  mode_q, mode_d;
    logic [DIV_W-1:0]    p_q, p_d;
    logic [DIV_W-1:0]    x_q, x_d;
    logic [1:0]          e_q, e_d;
    logic                nrm_wait_q, nrm_wait_d;
    logic                uf_q, uf_d;
    logic                ovf_q, ovf_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;
    logic [4*DIGITS-1:0] obcd_q, obcd_d;
    logic [DIGITS-1:0]   odp_q, odp_d;
    logic                oovf_q, oovf_d;
    logic                ouf_q, ouf_d;
    logic                odone_q, odone_d;

    logic                launch;
    t_mode               launch_mode;
    logic [4*DIGITS-1:0] dab;
    logic                div_start;
    logic [DIV_W-1:0]    div_dividend;
    logic [DIV_W-1:0]    div_divisor;
    logic                div_done;
    logic [DIV_W-1:0]    div_quot;

    div_serial #(.WIDTH(DIV_W)) u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (div_start),
        .i_dividend (div_dividend),
        .i_divisor  (div_divisor),
        .o_done     (div_done),
        .o_quotient (div_quot)
    );

    // Two synchroniser flops, one history flop, and a registered edge strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], i_signal};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= e_mode_period;
            p_q        <= '0;
            x_q        <= '0;
            e_q        <= '0;
            nrm_wait_q <= 1'b0;
            uf_q       <= 1'b0;
            ovf_q      <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bcnt_q     <= '0;
            obcd_q     <= '0;
            odp_q      <= '0;
            oovf_q     <= 1'b0;
            ouf_q      <= 1'b0;
            odone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            p_q        <= p_d;
            x_q        <= x_d;
            e_q        <= e_d;
            nrm_wait_q <= nrm_wait_d;
            uf_q       <= uf_d;
            ovf_q      <= ovf_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bcnt_q     <= bcnt_d;
            obcd_q     <= obcd_d;
            odp_q      <= odp_d;
            oovf_q     <= oovf_d;
            ouf_q      <= ouf_d;
            odone_q    <= odone_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        p_d          = p_q;
        x_d          = x_q;
        e_d          = e_q;
        nrm_wait_d   = nrm_wait_q;
        uf_d         = uf_q;
        ovf_d        = ovf_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        bcnt_d       = bcnt_q;
        obcd_d       = obcd_q;
        odp_d        = odp_q;
        oovf_d       = oovf_q;
        ouf_d        = ouf_q;
        odone_d      = 1'b0;
        launch       = 1'b0;
        launch_mode  = mode_q;
        dab          = bcd_q;
        div_start    = 1'b0;
        div_dividend = x_q;
        div_divisor  = DIV_W'(10);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    launch      = 1'b1;
                    launch_mode = decode_mode(i_mode);
                    mode_d      = launch_mode;
                end
            end
            S_ARM: begin
                if (edge_q) begin
                    state_d = S_PERIOD;
                    p_d     = DIV_W'(1);
                end else if (p_q == DIV_W'(CLK_FREQ - 1)) begin
                    uf_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    p_d = p_q + DIV_W'(1);
                end
            end
            S_PERIOD: begin
                if (p_q == DIV_W'(CLK_FREQ)) begin
                    uf_d    = 1'b1;
                    state_d = S_DONE;
                end else if (edge_q) begin
                    if (mode_q == e_mode_auto && p_q < DIV_W'(AUTO_THRESH)) begin
                        state_d = S_GATE;
                        p_d     = DIV_W'(1);
                        x_d     = '0;
                    end else begin
                        div_start    = 1'b1;
                        div_dividend = RECIP_NUM;
                        div_divisor  = p_q;
                        state_d      = S_RECIP;
                    end
                end else begin
                    p_d = p_q + DIV_W'(1);
                end
            end
            S_GATE: begin
                x_d = x_q + DIV_W'(edge_q);
                if (p_q == DIV_W'(CLK_FREQ)) begin
                    state_d = S_SCALE;
                end else begin
                    p_d = p_q + DIV_W'(1);
                end
            end
            S_SCALE: begin
                x_d        = (x_q << 10) - (x_q << 4) - (x_q << 3);
                e_d        = 2'd3;
                nrm_wait_d = 1'b0;
                state_d    = S_NORM;
            end
            S_RECIP: begin
                if (div_done) begin
                    x_d        = div_quot;
                    e_d        = 2'd3;
                    nrm_wait_d = 1'b0;
                    state_d    = S_NORM;
                end
            end
            S_NORM: begin
                // Alternates between a range check and a shared-divider /10 step.
                if (nrm_wait_q) begin
                    if (div_done) begin
                        x_d        = div_quot;
                        e_d        = e_q - 2'd1;
                        nrm_wait_d = 1'b0;
                    end
                end else if (64'(x_q) >= LIMIT) begin
                    if (e_q == 2'd0) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        div_start  = 1'b1;
                        nrm_wait_d = 1'b1;
                    end
                end else begin
                    bin_d   = BIN_W'(x_q);
                    bcd_d   = '0;
                    bcnt_d  = '0;
                    state_d = S_BCD;
                end
            end
            S_BCD: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (dab[4*i +: 4] >= 4'd5) begin
                        dab[4*i +: 4] = dab[4*i +: 4] + 4'd3;
                    end
                end
                bcd_d  = {dab[4*DIGITS-2:0], bin_q[BIN_W-1]};
                bin_d  = bin_q << 1;
                bcnt_d = bcnt_q + CNT_W'(1);
                if (bcnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                odone_d = 1'b1;
                oovf_d  = ovf_q;
                ouf_d   = uf_q;
                if (uf_q) begin
                    obcd_d = '0;
                    odp_d  = '0;
                end else if (ovf_q) begin
                    obcd_d = {DIGITS{4'h9}};
                    odp_d  = '0;
                end else begin
                    obcd_d = bcd_q;
                    odp_d  = (e_q != 2'd0) ? (DIGITS'(1) << e_q) : '0;
                end
                if (i_continuous) begin
                    launch = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            uf_d  = 1'b0;
            ovf_d = 1'b0;
            if (launch_mode == e_mode_gate) begin
                state_d = S_GATE;
                p_d     = DIV_W'(1);
                x_d     = '0;
            end else begin
                state_d = S_ARM;
                p_d     = '0;
            end
        end
    end

    assign o_bcd       = obcd_q;
    assign o_dp        = odp_q;
    assign o_overflow  = oovf_q;
    assign o_underflow = ouf_q;
    assign o_done      = odone_q;
    assign o_ready     = (state_q == S_IDLE);

endmodule

// File: tb/tb_freq_meter_autorange.sv
// Randomised scoreboard bench for freq_meter_autorange with an arithmetic reference model.
module tb_freq_meter_autorange;
    import freq_meter_pkg::*;

    localparam int unsigned CF     = 5000;
    localparam int unsigned DIG    = 3;
    localparam int unsigned THR    = 200;
    localparam int          BUDGET = 3 * CF + 2000;
    localparam int          K_RECIP = 0;
    localparam int          K_GATE  = 1;
    localparam int          K_UF    = 2;

    typedef struct packed {
        logic [4*DIG-1:0] bcd;
        logic [DIG-1:0]   dp;
        logic             ovf;
        logic             uf;
    } res_t;

    typedef struct {
        int kind;
        int t;
        int lo;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic cont = 1'b0;
    logic sig = 1'b0;
    logic [4*DIG-1:0] bcd;
    logic [DIG-1:0] dp;
    logic ovf, uf, ready, done;

    int total = 0;
    int bad = 0;
    int gen_period = 0;
    exp_t sb[$];

    freq_meter_autorange #(
        .CLK_FREQ    (CF),
        .DIGITS      (DIG),
        .AUTO_THRESH (THR)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_mode       (mode),
        .i_continuous (cont),
        .i_signal     (sig),
        .o_bcd        (bcd),
        .o_dp         (dp),
        .o_overflow   (ovf),
        .o_underflow  (uf),
        .o_ready      (ready),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Square wave with an exact period of gen_period clocks; 0 holds the line low.
    int gen_ph = 0;
    int gen_last = 0;
    always @(negedge clk) begin
        if (gen_period != gen_last) begin
            gen_last = gen_period;
            gen_ph = 0;
        end
        if (gen_period == 0) begin
            sig = 1'b0;
        end else begin
            sig = (gen_ph < gen_period / 2);
            gen_ph = (gen_ph + 1) % gen_period;
        end
    end

    // Reading in mHz with three fractional digits, trimmed to DIG significant digits.
    function automatic res_t res_of_x(input longint unsigned x_in);
        res_t r;
        longint unsigned x;
        longint unsigned lim;
        longint unsigned pw;
        int e;
        r = '0;
        x = x_in;
        e = 3;
        lim = 1;
        for (int unsigned i = 0; i < DIG; i++) lim = lim * 10;
        while (x >= lim && e > 0) begin
            x = x / 10;
            e = e - 1;
        end
        if (x >= lim) begin
            for (int unsigned i = 0; i < DIG; i++) r.bcd[4*i +: 4] = 4'd9;
            r.ovf = 1'b1;
        end else begin
            pw = 1;
            for (int unsigned i = 0; i < DIG; i++) begin
                r.bcd[4*i +: 4] = 4'((x / pw) % 10);
                pw = pw * 10;
            end
            if (e > 0 && e < int'(DIG)) r.dp[e] = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t model_expect(input logic [1:0] m, input int t);
        exp_t x;
        x.t = t;
        x.lo = 0;
        x.hi = 0;
        if (m == 2'd1 || (m != 2'd0 && t > 0 && t < int'(THR))) begin
            x.kind = K_GATE;
            if (t > 0) begin
                x.lo = int'(CF) / t;
                x.hi = (int'(CF) + t - 1) / t;
            end
        end else if (t == 0 || t >= int'(CF)) begin
            x.kind = K_UF;
        end else begin
            x.kind = K_RECIP;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            res_t got;
            res_t req;
            exp_t ex;
            logic ok;
            got.bcd = bcd;
            got.dp = dp;
            got.ovf = ovf;
            got.uf = uf;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got o_done=1 bcd=%h, required no result pending", bcd);
            end else begin
                ex = sb.pop_front();
                ok = 1'b0;
                req = '0;
                if (ex.kind == K_UF) begin
                    req.uf = 1'b1;
                    ok = (got == req);
                end else if (ex.kind == K_RECIP) begin
                    req = res_of_x(longint'(CF) * 1000 / longint'(ex.t));
                    ok = (got == req);
                end else begin
                    for (int c = ex.lo; c <= ex.hi; c++) begin
                        req = res_of_x(longint'(c) * 1000);
                        if (got == req) ok = 1'b1;
                    end
                end
                if (!ok) begin
                    bad++;
                    $display("FAIL result kind=%0d T=%0d: got bcd=%h dp=%b ovf=%b uf=%b, required bcd=%h dp=%b ovf=%b uf=%b (counts %0d..%0d)",
                             ex.kind, ex.t, got.bcd, got.dp, got.ovf, got.uf,
                             req.bcd, req.dp, req.ovf, req.uf, ex.lo, ex.hi);
                end
            end
        end
    end

    task automatic set_period(input int t);
        gen_period = t;
        repeat (2 * t + 8) @(negedge clk);
    endtask

    task automatic start_meas(input logic [1:0] m);
        sb.push_back(model_expect(m, gen_period));
        @(negedge clk);
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d results pending after %0d cycles, required 0", sb.size(), n);
            sb.delete();
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_done: got %b, required 1", ready);
        end
    endtask

    task automatic run_one(input logic [1:0] m, input int t);
        set_period(t);
        start_meas(m);
        wait_drain();
    endtask

    initial begin
        logic ready_low_ok;
        int n;

        repeat (3) @(negedge clk);
        total++;
        if (bcd !== '0 || dp !== '0 || ovf !== 1'b0 || uf !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got bcd=%h dp=%b ovf=%b uf=%b done=%b ready=%b, required 0 0 0 0 0 1",
                     bcd, dp, ovf, uf, done, ready);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_one(2'd0, 400);
        run_one(2'd0, 3000);
        for (int i = 0; i < 4; i++) run_one(2'd0, int'($urandom_range(1200, 210)));
        run_one(2'd0, 0);
        run_one(2'd1, 4);

        // A start pulse while busy must not disturb the gated measurement.
        set_period(int'($urandom_range(200, 5)));
        start_meas(2'd1);
        repeat (1000) @(negedge clk);
        mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        run_one(2'd2, 60);
        run_one(2'd3, 1000);
        run_one(2'd2, int'($urandom_range(1200, 250)));

        set_period(300);
        cont = 1'b1;
        sb.push_back(model_expect(2'd0, 300));
        sb.push_back(model_expect(2'd0, 300));
        start_meas(2'd0);
        ready_low_ok = 1'b1;
        n = 0;
        while (sb.size() > 1 && n < 2 * BUDGET) begin
            if (ready !== 1'b0) ready_low_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        cont = 1'b0;
        total++;
        if (!ready_low_ok || sb.size() > 1) begin
            bad++;
            $display("FAIL continuous_ready: got ready_low=%b pending=%0d, required ready_low=1 pending<=1",
                     ready_low_ok, sb.size());
        end
        wait_drain();

        set_period(300);
        start_meas(2'd0);
        n = 0;
        while (dut.state_q != S_RECIP && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (dut.state_q != S_RECIP) begin
            bad++;
            $display("FAIL reach_recip: got no RECIP within %0d cycles, required RECIP", n);
        end
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        total++;
        if (bcd !== '0 || dp !== '0 || ovf !== 1'b0 || uf !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL midrun_reset: got bcd=%h dp=%b ovf=%b uf=%b done=%b ready=%b, required 0 0 0 0 0 1",
                     bcd, dp, ovf, uf, done, ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        total++;
        if (ready !== 1'b1 || bcd !== '0) begin
            bad++;
            $display("FAIL after_reset: got ready=%b bcd=%h, required ready=1 bcd=0", ready, bcd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
